// File: rtl/mem_access_unit.sv
// Load/store front-end between the MEM stage and a word-wide block RAM.
// Define MEM_PERF_CNT_EN to build the completed load/store counters.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RMW_WR  = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

    logic [1:0]  state;
    logic        l_signed;
    logic [1:0]  l_size;
    logic [31:0] l_addr;
    logic [15:0] l_wdata;
    logic        accept;
    logic        bad;
    logic        word_st;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign word_st   = req_we && (req_size == 2'b10);

    // Classify the incoming request as illegal before any RAM access
    always_comb begin
        bad = (req_size == 2'b11)
           || ((req_size == 2'b01) && req_addr[0])
           || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
           || ({1'b0, req_addr} >= LIMIT);
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        unique case (l_addr[1:0])
            2'd0: lane_b = ram_dout[7:0];
            2'd1: lane_b = ram_dout[15:8];
            2'd2: lane_b = ram_dout[23:16];
            default: lane_b = ram_dout[31:24];
        endcase
        lane_h = l_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
        unique case (l_size)
            2'b00: load_val = l_signed ? {{24{lane_b[7]}}, lane_b}
                                       : {24'h0, lane_b};
            2'b01: load_val = l_signed ? {{16{lane_h[15]}}, lane_h}
                                       : {16'h0, lane_h};
            default: load_val = ram_dout;
        endcase
        merged = ram_dout;
        if (l_size == 2'b00) begin
            unique case (l_addr[1:0])
                2'd0: merged[7:0]   = l_wdata[7:0];
                2'd1: merged[15:8]  = l_wdata[7:0];
                2'd2: merged[23:16] = l_wdata[7:0];
                default: merged[31:24] = l_wdata[7:0];
            endcase
        end else if (l_addr[1]) begin
            merged[31:16] = l_wdata;
        end else begin
            merged[15:0] = l_wdata;
        end
    end

    // RAM drive: read/word-write straight from the request, RMW write from the latch
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {l_addr[31:2], 2'b00};
        ram_di   = merged;
        if (state == IDLE) begin
            ram_addr = {req_addr[31:2], 2'b00};
            ram_di   = req_wdata;
            if (req_valid && !bad && !rst) begin
                ram_en = 1'b1;
                ram_we = word_st;
            end
        end else if (state == RMW_WR && !rst) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end
    end

    // Capture request fields at accept; they stay stable for the whole op
    always_ff @(posedge clk) begin
        if (accept) begin
            l_signed <= req_signed;
            l_size   <= req_size;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata[15:0];
        end
    end

    // Sequencer and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad || word_st) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= bad;
                            resp_rdata <= 32'h0;
                        end else if (req_we) begin
                            state <= RMW_WR;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_val;
                end
                RMW_WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    // Count successful completions at the edge that raises resp_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads  <= 32'h0;
            perf_stores <= 32'h0;
        end else if (state == RD_WAIT) begin
            perf_loads <= perf_loads + 32'd1;
        end else if (state == RMW_WR) begin
            perf_stores <= perf_stores + 32'd1;
        end else if (accept && !bad && word_st) begin
            perf_stores <= perf_stores + 32'd1;
        end
    end
`else
    assign perf_loads  = 32'h0;
    assign perf_stores = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level reference memory
// and an in-order expected-response queue.
module tb_mem_access_unit;

    localparam int unsigned MB = 1048576;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout),
        .perf_loads(perf_loads), .perf_stores(perf_stores)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr[11:2]] <= ram_di;
            ram_dout <= ram[ram_addr[11:2]];
        end
    end

    logic [7:0] rmem [0:4095];

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        logic        has_lit;
        logic        lerr;
        logic [31:0] lit;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model(input logic we, input logic [1:0] size,
                                  input logic sgn, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rd,
                                  output int lat);
        int nb;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
           || (size == 2'd2 && addr % 4 != 0) || (addr >= MB);
        rd  = 32'h0;
        lat = 1;
        if (err) return;
        nb = 1 << size;
        if (we) begin
            for (int i = 0; i < nb; i++)
                rmem[addr + i] = wdata[8*i +: 8];
            lat = (size == 2'd2) ? 1 : 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = rmem[addr + i];
            if (sgn && nb < 4 && v[8*nb-1])
                v = v | ~((32'd1 << (8*nb)) - 32'd1);
            rd  = v;
            lat = 2;
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic has_lit,
                          input logic lerr, input logic [31:0] lit);
        int n;
        logic e_err;
        logic [31:0] e_rd;
        int lat;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        model(we, size, sgn, addr, wdata, e_err, e_rd, lat);
        q.push_back('{cyc + lat, e_err, e_rd, has_lit, lerr, lit});
        if (e_err) begin
            #1 chk("err_ram_en_e0", {31'h0, ram_en}, 32'h0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (e_err) chk("err_ram_en_e1", {31'h0, ram_en}, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d expected 0", q.size());
            q.delete();
        end
    endtask

    // Response checker against the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_resp: got 1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    if (e.has_lit) begin
                        chk("lit_rdata", resp_rdata, e.lit);
                        chk("lit_err", {31'h0, resp_err}, {31'h0, e.lerr});
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                checks++;
                failures++;
                $display("FAIL missing_resp: got 0 expected 1");
                void'(q.pop_front());
            end
            if (ram_en) chk("ram_addr_align", {30'h0, ram_addr[1:0]}, 32'h0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) rmem[i] = 8'h0;

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h100;
        req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_perf_loads", perf_loads, 32'h0);
        chk("rst_perf_stores", perf_stores, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;

        do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF);

        do_req(1, 2'd2, 0, 32'h200, 32'h11223344, 1, 0, 32'h0);
        do_req(1, 2'd0, 0, 32'h201, 32'h000000AA, 1, 0, 32'h0);
        do_req(0, 2'd2, 0, 32'h200, 32'h0, 1, 0, 32'h1122AA44);
        do_req(0, 2'd0, 1, 32'h201, 32'h0, 1, 0, 32'hFFFFFFAA);
        do_req(0, 2'd0, 0, 32'h201, 32'h0, 1, 0, 32'h000000AA);

        do_req(1, 2'd2, 0, 32'h200, 32'h80017FFF, 1, 0, 32'h0);
        do_req(0, 2'd1, 1, 32'h202, 32'h0, 1, 0, 32'hFFFF8001);
        do_req(0, 2'd1, 0, 32'h200, 32'h0, 1, 0, 32'h00007FFF);
        do_req(1, 2'd1, 0, 32'h202, 32'hCAFE1234, 1, 0, 32'h0);
        do_req(0, 2'd2, 0, 32'h200, 32'h0, 1, 0, 32'h12347FFF);
        do_req(0, 2'd0, 1, 32'h203, 32'h0, 1, 0, 32'h00000012);

        do_req(0, 2'd2, 0, 32'h102, 32'h0, 1, 1, 32'h0);
        do_req(0, 2'd1, 0, 32'h103, 32'h0, 1, 1, 32'h0);
        do_req(0, 2'd3, 0, 32'h100, 32'h0, 1, 1, 32'h0);
        do_req(0, 2'd2, 0, MB, 32'h0, 1, 1, 32'h0);
        do_req(1, 2'd2, 0, 32'h101, 32'h12345678, 1, 1, 32'h0);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF);

        do_req(1, 2'd2, 0, 32'h300, 32'h55555555, 1, 0, 32'h0);
        drain();
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h300;
        req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rmw_rst_ram_we", {31'h0, ram_we}, 32'h0);
        @(negedge clk);
        chk("rmw_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rmw_rst_req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rmw_rst_resp_valid2", {31'h0, resp_valid}, 32'h0);
        chk("rmw_rst_req_ready2", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        do_req(0, 2'd2, 0, 32'h300, 32'h0, 1, 0, 32'h55555555);
        drain();

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 32'h0);
        do_req(1, 2'd2, 0, 32'h104, 32'h00000001, 0, 0, 32'h0);
        do_req(0, 2'd0, 0, 32'h201, 32'h0, 0, 0, 32'h0);
        do_req(0, 2'd1, 0, 32'h103, 32'h0, 1, 1, 32'h0);
        do_req(1, 2'd0, 0, 32'h105, 32'h00000002, 0, 0, 32'h0);
        do_req(0, 2'd1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
        drain();
        repeat (2) @(negedge clk);
`ifdef MEM_PERF_CNT_EN
        chk("perf_loads", perf_loads, 32'd3);
        chk("perf_stores", perf_stores, 32'd2);
`else
        chk("perf_loads", perf_loads, 32'd0);
        chk("perf_stores", perf_stores, 32'd0);
`endif
        do_req(0, 2'd2, 0, 32'h104, 32'h0, 1, 0, 32'h00000201);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
